// File: rtl/servo_pwm.sv
// servo_pwm: hobby-servo PWM generator.
// A free-running frame counter produces one pulse per frame, with the
// width set by the position latched at the end of the previous frame.
// Optional feature macro: SERVO_PWM_SLEW_EN limits how far the applied
// position may move per frame (by SLEW_STEP); without it the target
// position is loaded directly.
module servo_pwm #(
  parameter int unsigned FRAME_CYCLES = 1000000,
  parameter int unsigned MIN_CYCLES   = 50000,
  parameter int unsigned STEP_CYCLES  = 196,
  parameter int unsigned RESET_POS    = 128,
  parameter int unsigned SLEW_STEP    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] pos,
  input  logic       enable,
  output logic       servo_pulse,
  output logic       frame_start,
  output logic [7:0] pos_applied
);

  localparam logic [19:0] LAST_CNT    = 20'(FRAME_CYCLES - 1);
  localparam logic [31:0] WIDTH_LIMIT = 32'(FRAME_CYCLES - 1);
  localparam logic [7:0]  RESET_POS_L = 8'(RESET_POS);

  logic [19:0] cnt_q, cnt_d;
  logic        en_l_q, en_l_d;
  logic [7:0]  pos_applied_q, pos_applied_d;
  logic        servo_pulse_q, servo_pulse_d;
  logic        frame_start_q, frame_start_d;

  logic        frame_end;
  logic [7:0]  pos_next;
  logic [31:0] width_full;
  logic [19:0] width;

`ifdef SERVO_PWM_SLEW_EN
  localparam logic signed [8:0] SLEW_S = 9'(SLEW_STEP);
  logic signed [8:0] pos_diff;

  // Step the applied position toward the target by at most SLEW_STEP;
  // the final partial step lands exactly on the target, so no overshoot.
  always_comb begin
    pos_diff = $signed({1'b0, pos}) - $signed({1'b0, pos_applied_q});
    if (pos_diff > SLEW_S) begin
      pos_next = pos_applied_q + 8'(SLEW_STEP);
    end else if (pos_diff < -SLEW_S) begin
      pos_next = pos_applied_q - 8'(SLEW_STEP);
    end else begin
      pos_next = pos;
    end
  end
`else
  // Without slew limiting the target is applied as-is at frame end.
  always_comb begin
    pos_next = pos;
  end
`endif

  // Pulse width from the applied position, clamped below the frame length
  // so a mis-parameterised instance still produces one low cycle per frame.
  always_comb begin
    width_full = 32'(MIN_CYCLES) + (32'(pos_applied_q) * 32'(STEP_CYCLES));
    if (width_full > WIDTH_LIMIT) begin
      width = LAST_CNT;
    end else begin
      width = width_full[19:0];
    end
  end

  // Next-state logic: counter wrap, frame-end sampling of inputs, and the
  // registered pulse/strobe that lag the counter by one cycle.
  always_comb begin
    frame_end     = (cnt_q == LAST_CNT);
    cnt_d         = frame_end ? 20'd0 : cnt_q + 20'd1;
    en_l_d        = en_l_q;
    pos_applied_d = pos_applied_q;
    if (frame_end) begin
      en_l_d        = enable;
      pos_applied_d = pos_next;
    end
    servo_pulse_d = en_l_q && (cnt_q < width);
    frame_start_d = (cnt_q == 20'd0);
  end

  // State registers; reset clears the pulse immediately without a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q         <= 20'd0;
      en_l_q        <= 1'b0;
      pos_applied_q <= RESET_POS_L;
      servo_pulse_q <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      en_l_q        <= en_l_d;
      pos_applied_q <= pos_applied_d;
      servo_pulse_q <= servo_pulse_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign servo_pulse = servo_pulse_q;
  assign frame_start = frame_start_q;
  assign pos_applied = pos_applied_q;

endmodule

// File: doc/servo_pwm.md
SERVO_PWM -- requirements
Module: servo_pwm

Interface
REQ-001 Parameter FRAME_CYCLES, default 1000000, sets the PWM frame length in clk cycles (20 ms at 50 MHz).
REQ-002 Parameter MIN_CYCLES, default 50000, sets the pulse width for pos=0 (1 ms).
REQ-003 Parameter STEP_CYCLES, default 196, sets the added pulse width per LSB of pos.
REQ-004 Parameter RESET_POS, default 128, sets the applied position after reset (servo centre).
REQ-005 Parameter SLEW_STEP, default 4, sets the maximum change of applied position per frame (used only with SERVO_PWM_SLEW_EN).
REQ-006 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-007 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-008 Port pos, input, 8 bits: target position from the servo_controller, 0..255.
REQ-009 Port enable, input, 1 bit: when low, pulses are suppressed for the following frame.
REQ-010 Port servo_pulse, output, 1 bit: registered PWM drive to the servo pin.
REQ-011 Port frame_start, output, 1 bit: registered one-cycle strobe marking the first cycle of each frame.
REQ-012 Port pos_applied, output, 8 bits: registered position currently being driven.

Function
REQ-013 The frame counter cnt (20 bits) SHALL count 0..FRAME_CYCLES-1, then wrap to 0, free-running.
REQ-014 When cnt==FRAME_CYCLES-1, the block SHALL latch en_l<=enable and update pos_applied; pos and enable are ignored at every other cnt value, so mid-frame changes never alter the current frame.
REQ-015 The width SHALL be MIN_CYCLES + pos_applied*STEP_CYCLES, computed unsigned at 20 bits, with no truncation for any 8-bit pos.
REQ-016 The next-cycle value of servo_pulse SHALL be en_l AND (cnt < width), giving exactly width high cycles per enabled frame (1-cycle latency from cnt).
REQ-017 The next-cycle value of frame_start SHALL be (cnt==0), so frame_start coincides with the first high cycle of servo_pulse.
REQ-018 servo_pulse SHALL be low for the entire frame when en_l==0; frame_start continues regardless of enable.
REQ-019 pos=0 SHALL yield a 50000-cycle pulse and pos=255 a 99980-cycle pulse with default parameters; the result SHALL be glitch-free (a single rising and falling edge per frame).
REQ-020 Parameters SHALL satisfy MIN_CYCLES+255*STEP_CYCLES < FRAME_CYCLES; when violated, width SHALL be clamped to FRAME_CYCLES-1.

Reset
REQ-021 While rst_n==0, the block SHALL hold cnt=0, en_l=0, pos_applied=RESET_POS, servo_pulse=0 and frame_start=0, asynchronously.
REQ-022 In the first cycle after rst_n rises, cnt SHALL be 0, so frame_start pulses on the second cycle; the first frame SHALL output no pulse because en_l==0.
REQ-023 Reset asserted mid-pulse SHALL drop servo_pulse immediately, without waiting for a clock edge.

Configuration
REQ-024 With SERVO_PWM_SLEW_EN defined, the update at frame end SHALL move pos_applied toward pos by min(|pos-pos_applied|, SLEW_STEP) using 9-bit signed difference arithmetic, never overshooting and never wrapping past 0 or 255.
REQ-025 Without SERVO_PWM_SLEW_EN, the update SHALL load pos_applied<=pos directly, and SLEW_STEP SHALL be unused.

Verification
REQ-026 Reset -> release; enable=1, pos=0 -> frame 1 has no pulse; frame 2 has a 50000-cycle pulse; frame_start occurs every 1000000 cycles.
REQ-027 pos=255, enable=1 (no slew) -> 99980 high cycles followed by 900020 low cycles, repeating.
REQ-028 Change pos 0->200 at cnt=10000 -> the current frame remains 50000 cycles; the next frame is 50000+200*196=89200 cycles.
REQ-029 Drop enable to 0 for a mid-frame cycle only, then restore it -> the current pulse is unaffected and the next frame is unaffected (enable sampled only at frame end).
REQ-030 With SERVO_PWM_SLEW_EN, start from pos_applied=128 with pos=138 -> pos_applied takes 132, 136, 138 over three frames; with pos=2 from 4 -> 2, never below 0.
REQ-031 Assert rst_n low during a pulse at cnt=30000 -> servo_pulse goes to 0 asynchronously; after release, pos_applied=128 and cnt restarts at 0.
